// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - SEG/COM scan lines and decoded display results
interface seg_scan_decoder_if;
  logic [7:0] SEG;
  logic [1:0] COM;
  logic [3:0] Digit0;
  logic [3:0] Digit1;
  logic [1:0] DP;
  logic [1:0] Seg_Err;
  logic       Frame_Valid;
  logic       Blank;

  modport master (
    output SEG, COM,
    input  Digit0, Digit1, DP, Seg_Err, Frame_Valid, Blank
  );

  modport slave (
    input  SEG, COM,
    output Digit0, Digit1, DP, Seg_Err, Frame_Valid, Blank
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers two multiplexed seven-segment digits from SEG/COM scan lines
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input logic             Sys_CLK,
  input logic             Sys_RST,
  seg_scan_decoder_if.slave bus
);

  localparam logic [7:0]  STABLE  = 8'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  logic [7:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [1:0]  com_s1_q, com_s1_d, com_s2_q, com_s2_d;
  logic [8:0]  prev_q, prev_d;
  logic [7:0]  run_q, run_d;
  logic [15:0] idle_q, idle_d;
  logic [1:0]  got_q, got_d;
  logic [3:0]  digit0_q, digit0_d, digit1_q, digit1_d;
  logic [1:0]  dp_q, dp_d, err_q, err_d;
  logic        frame_q, frame_d, blank_q, blank_d;

  logic [7:0]  seg_n;
  logic [1:0]  com_n;
  logic        sel_valid, sel, capture, hit;
  logic [3:0]  value;

  // Returns {hit, value} for an active-high {g..a} pattern.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0_0000;
    case (p)
      7'h3F: r = 5'h10;  7'h06: r = 5'h11;  7'h5B: r = 5'h12;  7'h4F: r = 5'h13;
      7'h66: r = 5'h14;  7'h6D: r = 5'h15;  7'h7D: r = 5'h16;  7'h07: r = 5'h17;
      7'h7F: r = 5'h18;  7'h6F: r = 5'h19;  7'h77: r = 5'h1A;  7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;  7'h5E: r = 5'h1D;  7'h79: r = 5'h1E;  7'h71: r = 5'h1F;
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    seg_s1_d  = bus.SEG;
    seg_s2_d  = seg_s1_q;
    com_s1_d  = bus.COM;
    com_s2_d  = com_s1_q;
    seg_n     = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
    com_n     = COM_ACTIVE_LOW ? ~com_s2_q : com_s2_q;
    sel_valid = com_n[0] ^ com_n[1];
    sel       = com_n[1];
    {hit, value} = decode(seg_n[6:0]);

    prev_d   = prev_q;
    run_d    = run_q;
    capture  = 1'b0;
    idle_d   = idle_q;
    got_d    = got_q;
    digit0_d = digit0_q;
    digit1_d = digit1_q;
    dp_d     = dp_q;
    err_d    = err_q;
    blank_d  = blank_q;
    frame_d  = (got_q == 2'b11);

    // Capture only on the transition into STABLE so a held pattern fires once.
    if (!sel_valid) begin
      run_d = 8'd0;
    end else if ({sel, seg_n} == prev_q) begin
      if (run_q != STABLE) run_d = run_q + 8'd1;
      capture = (run_d == STABLE) && (run_q != STABLE);
    end else begin
      run_d   = 8'd1;
      prev_d  = {sel, seg_n};
      capture = (STABLE == 8'd1);
    end

    if (frame_d) got_d = 2'b00;

    if (capture) begin
      dp_d[sel]  = seg_n[7];
      err_d[sel] = ~hit;
      got_d[sel] = 1'b1;
      if (hit && !sel) digit0_d = value;
      if (hit && sel)  digit1_d = value;
      idle_d  = 16'd0;
      blank_d = 1'b0;
    end else begin
      if (idle_q != TIMEOUT) idle_d = idle_q + 16'd1;
      if (idle_d == TIMEOUT) begin
        blank_d = 1'b1;
        got_d   = 2'b00;
      end
    end
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      com_s1_q <= '0;
      com_s2_q <= '0;
      prev_q   <= '0;
      run_q    <= '0;
      idle_q   <= '0;
      got_q    <= '0;
      digit0_q <= '0;
      digit1_q <= '0;
      dp_q     <= '0;
      err_q    <= '0;
      frame_q  <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      seg_s1_q <= seg_s1_d;
      seg_s2_q <= seg_s2_d;
      com_s1_q <= com_s1_d;
      com_s2_q <= com_s2_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      idle_q   <= idle_d;
      got_q    <= got_d;
      digit0_q <= digit0_d;
      digit1_q <= digit1_d;
      dp_q     <= dp_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
      blank_q  <= blank_d;
    end
  end

  assign bus.Digit0      = digit0_q;
  assign bus.Digit1      = digit1_q;
  assign bus.DP          = dp_q;
  assign bus.Seg_Err     = err_q;
  assign bus.Frame_Valid = frame_q;
  assign bus.Blank       = blank_q;

endmodule
